// File: rtl/csa_resolver_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
// Chunk count and counter width are derived here so the RTL and its users agree.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices needed to cover the n+2 bit result.
    function automatic int nchunk(input int n, input int chunk);
        return (n + 2 + chunk - 1) / chunk;
    endfunction

    // Counter width for the chunk index, never narrower than one bit.
    function automatic int cnt_width(input int n, input int chunk);
        int c;
        c = nchunk(n, chunk);
        if (c <= 1) begin
            return 1;
        end else begin
            return $clog2(c);
        end
    endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used for one slice of the resolve per cycle.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c_s;

    // Bit-serial ripple through the slice
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
        end
        cout = c_s[CHUNK];
    end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into binary, CHUNK bits per cycle, LSB first.
// Valid/ready on both sides; one transaction in flight at a time.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   sum_in,
    input  logic [N-1:0]   carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+1:0]   result
);

    localparam int W   = N + 2;
    localparam int NCH = nchunk(N, CHUNK);
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = cnt_width(N, CHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    if (CHUNK < 1 || CHUNK > N + 2) begin : g_bad_chunk
        $error("csa_resolver: CHUNK must lie in 1..N+2");
    end

    state_t           state_r;
    logic [PW-1:0]    x_r;
    logic [PW-1:0]    y_r;
    logic [PW-1:0]    res_r;
    logic [CW-1:0]    idx_r;
    logic             carry_r;
    logic             out_valid_r;

    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] s_s;
    logic             cout_s;

    // Operands shift down each BUSY cycle, so the active chunk is always the low slice
    always_comb begin
        a_s = x_r[CHUNK-1:0];
        b_s = y_r[CHUNK-1:0];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_s),
        .b    (b_s),
        .cin  (carry_r),
        .s    (s_s),
        .cout (cout_s)
    );

    // Control FSM; result fills from the top so after NCH shifts chunk 0 sits at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= '0;
            y_r         <= '0;
            res_r       <= '0;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r     <= PW'(sum_in);
                        y_r     <= PW'({carry_in, 1'b0});
                        idx_r   <= '0;
                        carry_r <= 1'b0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    x_r     <= x_r >> CHUNK;
                    y_r     <= y_r >> CHUNK;
                    res_r   <= (res_r >> CHUNK) | (PW'(s_s) << (PW - CHUNK));
                    carry_r <= cout_s;
                    if (idx_r == LAST_IDX) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign result    = res_r[W-1:0];

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Sequential consumer for the carry-save adder output. Accepts a redundant (sum, carry) pair and resolves it to a plain binary value, result = sum + (carry << 1).
- The carry-propagate addition runs CHUNK bits per cycle, LSB first, to keep the adder short.
- Sits behind carrysave_adder in multi-operand accumulation paths.
- Valid/ready handshake on both input and output.

Parameters:
- N, 8, width of the sum and carry inputs (matches the carrysave_adder N).
- CHUNK, 4, bits resolved per cycle. Legal range 1..N+2; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sum_in/carry_in are valid.
- in_ready  out  1  block can accept an operand pair.
- sum_in  in  N  carry-save sum vector (bitwise XOR of the three CSA operands).
- carry_in  in  N  carry-save carry vector (bitwise majority), unshifted; weight is 2x.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  N+2  binary value, sum_in + 2*carry_in.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, out_valid=0, result=0, chunk counter=0, internal carry=0. in_ready=0 while rst is high.
- Reset mid-operation (BUSY or DONE) aborts the transaction. No output is produced for it.
- Operand width rules:
  - W = N+2.
  - X = zero-extended sum_in.
  - Y = zero-extended {carry_in, 1'b0}.
  - NCHUNK = ceil(W/CHUNK). Operands are internally padded to NCHUNK*CHUNK bits.
  - Padded high bits of the result are always 0, since the maximum value is 3*(2^N-1) < 2^W. They are dropped.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid is high at a rising edge: capture X and Y, clear the chunk index and carry, go to BUSY.
- BUSY:
  - in_ready=0 and out_valid=0.
  - Each cycle adds chunk i of X and Y with the stored carry, writes result bits [i*CHUNK +: CHUNK], stores carry-out, and increments i.
  - After chunk NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - result holds stable for as long as out_ready is low (backpressure of any length).
  - When out_ready is high at an edge, go to IDLE.
- in_valid outside IDLE is ignored and nothing is captured. sum_in/carry_in may change freely after acceptance.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. For N=8, CHUNK=4 this is 3 cycles.
- Throughput: one result per NCHUNK+2 cycles with out_ready tied high. There is no same-cycle IDLE re-accept from DONE.
- The final chunk's carry-out is discarded (always 0 by the width rule). No overflow output.
- result keeps its last value while in IDLE. Only the out_valid-qualified value is meaningful.

Decomposition:
- Package csa_pkg:
  - state_t enum {IDLE, BUSY, DONE}.
  - Function nchunk(n, chunk) returning ceil((n+2)/chunk).
  - Function for the counter width, $clog2 of nchunk with a minimum of 1.
- Sub-module chunk_adder #(CHUNK): combinational ripple adder with inputs a, b (CHUNK bits) and cin, outputs s (CHUNK bits) and cout. Instantiated once. The FSM muxes chunk slices into it.

Test Plan:
1. Basic resolve, N=8, CHUNK=4: sum_in=0, carry_in=5 -> result=10, out_valid high exactly 3 cycles after accept. Then sum_in=5, carry_in=5 -> 15.
2. Mixed carries: sum_in=10, carry_in=5 (CSA of 7, 9, 4) -> result=20. sum_in=0, carry_in=255 -> 510. sum_in=255, carry_in=255 -> 765, which exercises bit 9 and inter-chunk carry ripple.
3. Backpressure: hold out_ready=0 for 6 cycles after out_valid with sum_in=255, carry_in=255. result stays 765, in_ready stays 0, and a pulsed in_valid with other data is ignored. Release out_ready -> IDLE next cycle, in_ready=1.
4. Back-to-back: in_valid held high with out_ready=1 over 4 pairs -> 4 results in order, each spaced NCHUNK+2=5 cycles apart.
5. Reset mid-op: accept sum_in=255, carry_in=255, assert rst at the 2nd BUSY cycle. Next cycle out_valid=0, result=0, in_ready=1 after rst drops, and no result is emitted. A following sum_in=1, carry_in=1 -> 3.
6. Parameter sweep: CHUNK=1, 3, 10 with N=8 and random pairs -> result equals sum_in + 2*carry_in, latency equals ceil(10/CHUNK) cycles.
